// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial shift transmitter.
// Optional parity frame bit is enabled by defining SERIAL_TX_PARITY_EN.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } tx_state_t;

    localparam int NBITS_DATA_DEF = 4;

    // Keeps counters at least one bit wide even for degenerate moduli.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Modulo-MODULUS bit counter with synchronous clear/enable and terminal-count flag.
// Latency: count updates on the posedge after en_i; tc_o is combinational from the count register.
module tx_bit_counter
    import serial_tx_pkg::*;
#(
    parameter int MODULUS = NBITS_DATA_DEF
) (
    input  logic clk_2,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = cnt_width(MODULUS);
    localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    // Clear wins over enable; the terminal count wraps straight back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_shift_tx.sv
// Parallel-in/serial-out transmitter, LSB first, one bit per clk_2; Moore outputs only.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit (frame becomes NBITS_DATA+1 bits).
module serial_shift_tx
    import serial_tx_pkg::*;
#(
    parameter int NBITS_DATA = NBITS_DATA_DEF
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NBITS_DATA-1:0] data_in,
    output logic                  serial_out,
    output logic                  bit_valid,
    output logic                  busy,
    output logic                  done
);

    tx_state_t             state_q;
    tx_state_t             state_d;
    logic [NBITS_DATA-1:0] sreg_q;
    logic                  accept;
    logic                  last_bit;

`ifdef SERIAL_TX_PARITY_EN
    logic                  parity_q;
`endif

    assign accept = (state_q == IDLE) && start;

    tx_bit_counter #(
        .MODULUS (NBITS_DATA)
    ) u_cnt (
        .clk_2 (clk_2),
        .reset (reset),
        .clr_i (accept),
        .en_i  (state_q == SHIFT),
        .tc_o  (last_bit)
    );

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sreg_q <= data_in;
            end else if (state_q == SHIFT) begin
                sreg_q <= {1'b0, sreg_q[NBITS_DATA-1:1]};
            end
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Parity is taken from data_in at acceptance, so later data_in changes cannot corrupt it.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^data_in;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = SHIFT;
`ifdef SERIAL_TX_PARITY_EN
            SHIFT: if (last_bit) state_d = PAR;
            PAR:   state_d = DONE;
`else
            SHIFT: if (last_bit) state_d = DONE;
`endif
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        serial_out = 1'b0;
        bit_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            SHIFT: begin
                serial_out = sreg_q[0];
                bit_valid  = 1'b1;
                busy       = 1'b1;
            end
`ifdef SERIAL_TX_PARITY_EN
            PAR: begin
                serial_out = parity_q;
                bit_valid  = 1'b1;
                busy       = 1'b1;
            end
`endif
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_shift_tx.sv
// Directed bench for serial_shift_tx with a bit_valid-gated loopback receiver model.
// Honors SERIAL_TX_PARITY_EN the same way as the design.
module tb_serial_shift_tx;

    localparam int N = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int RXW = N + 1;
`else
    localparam int RXW = N;
`endif

    logic         clk_2 = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] data_in;
    logic         serial_out;
    logic         bit_valid;
    logic         busy;
    logic         done;

    logic [RXW-1:0] rx_q;
    logic           rx_clr;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [N-1:0] data;
        logic [0:N-1] seq;   // bits in transmit order, leftmost sent first
        logic         par;
    } vec_t;

    vec_t vecs [6];

    serial_shift_tx #(.NBITS_DATA(N)) dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .start      (start),
        .data_in    (data_in),
        .serial_out (serial_out),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_2 = ~clk_2;

    // Receiver: serial bit enters at MSB and shifts right while bit_valid.
    always @(posedge clk_2) begin
        if (rx_clr) rx_q <= '0;
        else if (bit_valid) rx_q <= {serial_out, rx_q[RXW-1:1]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    // Output bundle order: {serial_out, bit_valid, busy, done}
    task automatic chk_out(input string name, input logic [3:0] exp);
        chk(name, 32'({serial_out, bit_valid, busy, done}), 32'(exp));
    endtask

    task automatic run_frame(input string tag, input logic [N-1:0] d, input logic [0:N-1] seq,
                             input logic par, input bit inject);
        data_in = d;
        start   = 1'b1;
        rx_clr  = 1'b1;
        tick();
        start   = 1'b0;
        rx_clr  = 1'b0;
        data_in = ~d;
        for (int k = 0; k < N; k++) begin
            chk_out($sformatf("%s_bit%0d", tag, k), {seq[k], 3'b110});
            if (inject && k == 1) begin
                start   = 1'b1;
                data_in = 4'b0101;
            end
            tick();
            start = 1'b0;
        end
`ifdef SERIAL_TX_PARITY_EN
        chk_out($sformatf("%s_parity", tag), {par, 3'b110});
        tick();
`else
        if (par) begin end
`endif
        chk_out($sformatf("%s_done", tag), 4'b0011);
        tick();
        chk_out($sformatf("%s_idle", tag), 4'b0000);
        chk($sformatf("%s_loopback", tag), 32'(rx_q[N-1:0]), 32'(d));
    endtask

    initial begin
        vecs[0] = '{data: 4'b1011, seq: 4'b1101, par: 1'b1};
        vecs[1] = '{data: 4'b0000, seq: 4'b0000, par: 1'b0};
        vecs[2] = '{data: 4'b1111, seq: 4'b1111, par: 1'b0};
        vecs[3] = '{data: 4'b0110, seq: 4'b0110, par: 1'b0};
        vecs[4] = '{data: 4'b0111, seq: 4'b1110, par: 1'b1};
        vecs[5] = '{data: 4'b0101, seq: 4'b1010, par: 1'b0};

        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        rx_clr  = 1'b1;
        tick();
        tick();
        chk_out("reset_state", 4'b0000);

        // Asynchronous reset mid-cycle while a frame is in flight.
        reset = 1'b0;
        tick();
        data_in = 4'b1011;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk_out("pre_reset_bit0", 4'b1110);
        #2 reset = 1'b1;
        #1 chk_out("async_reset", 4'b0000);
        @(negedge clk_2);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("post_reset_idle%0d", i), 4'b0000);
        end

        for (int v = 0; v < 6; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].seq, vecs[v].par, 1'b0);
        end

        // start mid-frame must neither disturb nor queue a frame.
        run_frame("ignored_start", 4'b1011, 4'b1101, 1'b1, 1'b1);
        tick();
        chk_out("ignored_start_no_retrigger", 4'b0000);

        // Abort after bit 2 of 1001: no done pulse, then a clean frame.
        data_in = 4'b1001;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk_out("abort_bit0", 4'b1110);
        tick();
        chk_out("abort_bit1", 4'b0110);
        tick();
        chk_out("abort_bit2", 4'b0110);
        #2 reset = 1'b1;
        #1 chk_out("abort_async", 4'b0000);
        @(negedge clk_2);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("abort_no_done%0d", i), 4'b0000);
        end
        run_frame("after_abort", 4'b0011, 4'b1100, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
